mem_access_sequencer: RTL and testbench

- Shares one single-port, word-wide synchronous data memory between instruction fetch and the load/store path.
- The memory has no byte strobes, so byte and half stores are sequenced as read-modify-write (RMW).
- Load data returns lane-aligned to bits [7:0]/[15:0], ready for the downstream sign/zero-extension and load-select logic.
- Sits between the fetch unit, the load/store controller and the memory macro.

---
 rtl/mem_access_sequencer.sv | 106 ++++++++++
 tb/tb_mem_access_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: arbitrates fetch and load/store onto one single-port word memory, byte/half stores as RMW
module mem_access_sequencer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [31:0]           if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_wr,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [31:0]           ls_wdata,
  input  logic                  ls_b_e,
  input  logic                  ls_h_e,
  input  logic                  ls_w_e,
  output logic                  ls_ready,
  output logic [31:0]           ls_rdata,
  output logic                  misalign_err,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, MERGE_WR, ACK} state_t;
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [15:0]           r_wdata;
  logic [31:0]           r_word;
  logic [2:0]            r_cnt;
  logic                  r_b, r_h, r_wr, r_is_ls, r_last_ls, r_err;
  logic                  w_run, w_gnt_ls, w_gnt_if, w_oh, w_ill, w_wst, w_rd_wait, w_merge_st, w_last, w_ls_load;
  logic [31:0]           w_sh_b, w_sh_h, w_load, w_mask, w_ins, w_merge;

  // Grants are only decided in IDLE; ls wins a tie unless it won the previous grant.
  assign w_run      = rst_n && r_state == IDLE;
  assign w_gnt_ls   = w_run & ls_req & (~if_req | ~r_last_ls);
  assign w_gnt_if   = w_run & if_req & ~w_gnt_ls;
  assign w_oh       = (ls_b_e & ~ls_h_e & ~ls_w_e) | (~ls_b_e & ls_h_e & ~ls_w_e) | (~ls_b_e & ~ls_h_e & ls_w_e);
  assign w_ill      = ~w_oh | (ls_h_e & ls_addr[0]) | (ls_w_e & |ls_addr[1:0]);
  assign w_wst      = ls_wr & ls_w_e & ~w_ill;
  assign w_rd_wait  = r_state == RD_WAIT;
  assign w_merge_st = r_state == MERGE_WR;
  assign w_last     = w_rd_wait && r_cnt == 3'(MEM_LATENCY - 1);
  assign w_ls_load  = w_last & r_is_ls & ~r_wr;

  // Lane extraction for loads and lane replacement for the RMW write.
  assign w_sh_b  = mem_rdata >> {r_addr[1:0], 3'b0};
  assign w_sh_h  = mem_rdata >> {r_addr[1], 4'b0};
  assign w_load  = r_b ? {24'b0, w_sh_b[7:0]} : r_h ? {16'b0, w_sh_h[15:0]} : mem_rdata;
  assign w_mask  = r_b ? 32'hFF << {r_addr[1:0], 3'b0} : 32'hFFFF << {r_addr[1], 4'b0};
  assign w_ins   = r_b ? {4{r_wdata[7:0]}} : {2{r_wdata}};
  assign w_merge = (r_word & ~w_mask) | (w_ins & w_mask);

  assign mem_re       = w_gnt_if | (w_gnt_ls & ~w_ill & ~w_wst);
  assign mem_we       = (w_gnt_ls & w_wst) | w_merge_st;
  assign mem_wdata    = (w_gnt_ls & w_wst) ? ls_wdata : w_merge_st ? w_merge : '0;
  assign mem_addr     = w_gnt_ls ? ls_addr[ADDR_WIDTH-1:2] : w_gnt_if ? if_addr[ADDR_WIDTH-1:2] :
                        (w_rd_wait | w_merge_st) ? r_addr[ADDR_WIDTH-1:2] : '0;
  assign if_ready     = w_last & ~r_is_ls;
  assign if_rdata     = if_ready ? mem_rdata : '0;
  assign ls_ready     = w_ls_load | r_state == ACK;
  assign ls_rdata     = w_ls_load ? w_load : '0;
  assign misalign_err = r_state == ACK && r_err;

  // Sequencer: capture on grant, count read latency, merge and acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_word    <= '0;
      r_cnt     <= '0;
      r_b       <= 1'b0;
      r_h       <= 1'b0;
      r_wr      <= 1'b0;
      r_is_ls   <= 1'b0;
      r_last_ls <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_gnt_ls | w_gnt_if) begin
          r_addr    <= w_gnt_ls ? ls_addr : if_addr;
          r_wdata   <= ls_wdata[15:0];
          r_b       <= ls_b_e;
          r_h       <= ls_h_e;
          r_wr      <= w_gnt_ls & ls_wr;
          r_is_ls   <= w_gnt_ls;
          r_last_ls <= w_gnt_ls;
          r_err     <= w_gnt_ls & w_ill;
          r_cnt     <= '0;
          r_state   <= (w_gnt_ls & (w_ill | w_wst)) ? ACK : RD_WAIT;
        end
        RD_WAIT: if (w_last) begin
          r_word  <= mem_rdata;
          r_state <= (r_is_ls & r_wr) ? MERGE_WR : IDLE;
        end else r_cnt <= r_cnt + 3'd1;
        MERGE_WR: r_state <= ACK;
        default:  r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: transaction-level reference model with per-cycle output comparison
module tb_mem_access_sequencer;
  localparam int AW  = 32;
  localparam int LAT = 1;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          if_req = 0, ls_req = 0, ls_wr = 0, ls_b_e = 0, ls_h_e = 0, ls_w_e = 0;
  logic [AW-1:0] if_addr = '0, ls_addr = '0;
  logic [31:0]   ls_wdata = '0;
  logic          if_ready, ls_ready, misalign_err, mem_re, mem_we;
  logic [31:0]   if_rdata, ls_rdata, mem_wdata, mem_rdata;
  logic [AW-3:0] mem_addr;

  mem_access_sequencer #(.ADDR_WIDTH(AW), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_b_e(ls_b_e), .ls_h_e(ls_h_e), .ls_w_e(ls_w_e),
    .ls_ready(ls_ready), .ls_rdata(ls_rdata), .misalign_err(misalign_err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          re, we, ifr, lsr, err;
    logic [29:0] a;
    logic [31:0] wd, ifd, lsd;
  } slot_t;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] pipe [LAT];
  slot_t       sch [8];
  int          cyc = 0, free_at = 0, checks = 0, errors = 0, if_fin = 0, ls_fin = 0;
  bit          last_ls = 0;
  logic [31:0] rec_ifd, rec_lsd, rec_wd;
  logic [29:0] rec_re_a, rec_we_a;
  int          rec_re_n = 0, rec_we_n = 0, rec_lsr_cyc = 0;
  logic        rec_err;
  int          order[$];

  assign mem_rdata = pipe[LAT-1];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, act, exp);
    end
  endtask

  // Schedules every output event of a newly granted transaction from the access rules.
  task automatic grant(input int c);
    bit          gl;
    int          sz, nen, off;
    logic [31:0] word, m, nw;
    gl = ls_req && (!if_req || !last_ls);
    if (!gl) begin
      sch[c%8].re = 1; sch[c%8].a = if_addr[31:2];
      sch[(c+LAT)%8].ifr = 1; sch[(c+LAT)%8].ifd = ref_mem[if_addr[9:2]];
      free_at = c + LAT + 1; last_ls = 0;
      return;
    end
    last_ls = 1;
    sz   = ls_b_e ? 1 : ls_h_e ? 2 : 4;
    nen  = int'(ls_b_e) + int'(ls_h_e) + int'(ls_w_e);
    off  = int'(ls_addr[1:0]);
    word = ref_mem[ls_addr[9:2]];
    if (nen != 1 || off % sz != 0) begin
      sch[(c+1)%8].lsr = 1; sch[(c+1)%8].err = 1; sch[(c+1)%8].lsd = 0;
      free_at = c + 2;
    end else if (!ls_wr) begin
      m = sz == 1 ? 32'hFF : sz == 2 ? 32'hFFFF : 32'hFFFF_FFFF;
      sch[c%8].re = 1; sch[c%8].a = ls_addr[31:2];
      sch[(c+LAT)%8].lsr = 1; sch[(c+LAT)%8].lsd = (word >> (8 * off)) & m;
      free_at = c + LAT + 1;
    end else if (sz == 4) begin
      sch[c%8].we = 1; sch[c%8].a = ls_addr[31:2]; sch[c%8].wd = ls_wdata;
      sch[(c+1)%8].lsr = 1; sch[(c+1)%8].lsd = 0;
      free_at = c + 2;
    end else begin
      nw = word;
      for (int i = 0; i < sz; i++) nw[8*(off+i) +: 8] = ls_wdata[8*i +: 8];
      sch[c%8].re = 1; sch[c%8].a = ls_addr[31:2];
      sch[(c+LAT+1)%8].we = 1; sch[(c+LAT+1)%8].a = ls_addr[31:2]; sch[(c+LAT+1)%8].wd = nw;
      sch[(c+LAT+2)%8].lsr = 1; sch[(c+LAT+2)%8].lsd = 0;
      free_at = c + LAT + 3;
    end
  endtask

  task automatic model_cycle();
    slot_t s;
    if (!rst_n) begin
      chk("rst_strobes", {27'b0, if_ready, ls_ready, misalign_err, mem_re, mem_we}, 0);
      chk("rst_data", if_rdata | ls_rdata | mem_wdata | {2'b0, mem_addr}, 0);
      for (int k = 0; k < 8; k++) sch[k] = '{default: 0};
      free_at = cyc + 1; last_ls = 0; cyc++;
      return;
    end
    if (cyc >= free_at && (if_req || ls_req)) grant(cyc);
    else if (cyc >= free_at) chk("idle_mem_addr", {2'b0, mem_addr}, 0);
    s = sch[cyc%8];
    chk("mem_re", mem_re, s.re);
    chk("mem_we", mem_we, s.we);
    chk("if_ready", if_ready, s.ifr);
    chk("if_rdata", if_rdata, s.ifr ? s.ifd : 0);
    chk("ls_ready", ls_ready, s.lsr);
    chk("ls_rdata", ls_rdata, s.lsr ? s.lsd : 0);
    chk("misalign_err", misalign_err, s.err);
    if (s.re || s.we) chk("mem_addr", {2'b0, mem_addr}, {2'b0, s.a});
    if (s.we) begin
      chk("mem_wdata", mem_wdata, s.wd);
      ref_mem[s.a[7:0]] = s.wd;
    end
    if (mem_re) begin rec_re_n++; rec_re_a = mem_addr; end
    if (mem_we) begin rec_we_n++; rec_we_a = mem_addr; rec_wd = mem_wdata; end
    if (if_ready) begin rec_ifd = if_rdata; order.push_back(0); end
    if (ls_ready) begin rec_lsd = ls_rdata; rec_err = misalign_err; rec_lsr_cyc = cyc; order.push_back(1); end
    if (s.ifr) if_fin++;
    if (s.lsr) ls_fin++;
    sch[cyc%8] = '{default: 0};
    cyc++;
  endtask

  task automatic do_if(input logic [31:0] a);
    int st = if_fin;
    if_addr = a; if_req = 1;
    for (int t = 0; t < 40 && if_fin == st; t++) @(posedge clk);
    chk("if_done", if_fin - st, 1);
    #1 if_req = 0;
  endtask

  task automatic do_ls(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit b, input bit h, input bit w);
    int st = ls_fin;
    ls_wr = wr; ls_addr = a; ls_wdata = d; ls_b_e = b; ls_h_e = h; ls_w_e = w; ls_req = 1;
    for (int t = 0; t < 40 && ls_fin == st; t++) @(posedge clk);
    chk("ls_done", ls_fin - st, 1);
    #1 ls_req = 0;
  endtask

  task automatic rand_ls(input bit legal_only);
    int          k  = $urandom_range(0, 2);
    logic [31:0] a  = $urandom_range(0, 1023);
    logic [2:0]  en = 3'b1 << k;
    a = a & ~32'((1 << k) - 1);
    if (!legal_only && $urandom_range(0, 4) == 0) begin
      en = 3'($urandom);
      a  = $urandom_range(0, 1023);
    end
    do_ls(1'($urandom), a, $urandom, en[0], en[1], en[2]);
  endtask

  task automatic setw(input int i, input logic [31:0] v);
    mem[i] = v; ref_mem[i] = v;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  initial begin
    int n_re, n_we, st;
    for (int i = 0; i < 256; i++) setw(i, $urandom);
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
    fork
      forever begin
        @(posedge clk);
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        pipe[0] <= mem[mem_addr[7:0]];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      forever begin
        @(negedge clk);
        model_cycle();
      end
    join_none
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    setw(8'h41, 32'h1234_5678);
    do_if(32'h0000_0104);
    chk("t1_re_addr", {2'b0, rec_re_a}, 32'h41);
    chk("t1_if_rdata", rec_ifd, 32'h1234_5678);

    setw(8'h80, 32'hAABB_CCDD);
    do_ls(0, 32'h203, 0, 1, 0, 0);
    chk("t2_byte", rec_lsd, 32'h0000_00AA);
    do_ls(0, 32'h202, 0, 0, 1, 0);
    chk("t2_half", rec_lsd, 32'h0000_AABB);

    setw(8'h80, 32'h1122_3344);
    n_re = rec_re_n; n_we = rec_we_n; st = cyc;
    do_ls(1, 32'h201, 32'hFFFF_FF5A, 1, 0, 0);
    chk("t3_re_count", rec_re_n - n_re, 1);
    chk("t3_we_count", rec_we_n - n_we, 1);
    chk("t3_we_addr", {2'b0, rec_we_a}, 32'h80);
    chk("t3_wdata", rec_wd, 32'h1122_5A44);
    chk("t3_latency", rec_lsr_cyc - st, 3);
    @(posedge clk); #1;
    chk("t3_mem", mem[8'h80], 32'h1122_5A44);

    n_re = rec_re_n; n_we = rec_we_n; st = cyc;
    do_ls(0, 32'h3, 0, 0, 1, 0);
    chk("t5_err_half", rec_err, 1);
    chk("t5_rdata", rec_lsd, 0);
    chk("t5_latency", rec_lsr_cyc - st, 1);
    do_ls(1, 32'h2, 32'h1234_5678, 0, 0, 1);
    chk("t5_err_word", rec_err, 1);
    do_ls(0, 32'h100, 0, 1, 1, 0);
    chk("t5_err_onehot", rec_err, 1);
    chk("t5_no_strobes", rec_re_n - n_re + rec_we_n - n_we, 0);

    setw(8'h80, 32'hDEAD_BEEF);
    ls_wr = 1; ls_addr = 32'h200; ls_wdata = 32'h77; ls_b_e = 1; ls_h_e = 0; ls_w_e = 0; ls_req = 1;
    @(posedge clk); #2 rst_n = 0;
    #1;
    chk("t6_strobes", {27'b0, if_ready, ls_ready, misalign_err, mem_re, mem_we}, 0);
    chk("t6_mem_addr", {2'b0, mem_addr}, 0);
    ls_req = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("t6_mem_kept", mem[8'h80], 32'hDEAD_BEEF);
    do_if(32'h200);
    chk("t6_fetch", rec_ifd, 32'hDEAD_BEEF);

    order.delete();
    fork
      repeat (3) rand_ls(1);
      repeat (3) do_if($urandom_range(0, 1023));
    join
    chk("t4_count", order.size(), 6);
    for (int i = 0; i < order.size() && i < 6; i++) chk("t4_order", order[i], (i % 2 == 0) ? 1 : 0);

    fork
      repeat (30) begin gap(); rand_ls(0); end
      repeat (30) begin gap(); do_if($urandom_range(0, 1023)); end
    join
    repeat (3) @(posedge clk);
    for (int i = 0; i < 256; i++) chk("mem_final", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
